// File: rtl/uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// uart_sync_fifo
//   Single-clock byte FIFO that sits between the UART rx/tx shift engines and
//   the host register interface. It tracks occupancy exactly, including when a
//   read and a write happen in the same cycle. It provides registered
//   full/empty/almost flags and supports either a standard registered read or
//   a first-word-fall-through (FWFT) read.
//
//   Optional feature: define UART_FIFO_ERR_FLAGS_EN to get sticky
//   overflow/underflow flags cleared by clr_err. When the macro is not defined,
//   both flags are tied to 0 and clr_err is ignored.
//
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous reset, active-high
//   wr_en, din    write request / data (accepted when !full)
//   rd_en         read/pop request (accepted when !empty)
//   dout          read data (registered, or head-of-queue in FWFT mode)
//   full, empty   count == DEPTH / count == 0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         occupancy 0..DEPTH
//   clr_err       synchronous clear of the sticky error flags
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
// -----------------------------------------------------------------------------
module uart_sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 4,
    parameter int FWFT       = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [DATA_WIDTH-1:0]   din,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   dout,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count,
    input  logic                    clr_err,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_next;
    logic                  wr_acc;
    logic                  rd_acc;

    // Accepts are based on the registered flags from before the edge. This
    // means a full FIFO can still take a read in the same cycle, but it will
    // not take the write.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    assign count_next = count + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};

    // Pointers, count and flags. The flags are computed from count_next, so
    // they are valid in the same cycle as the count they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            count        <= count_next;
            full         <= (count_next == CW'(DEPTH));
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= CW'(AF_LEVEL));
            almost_empty <= (count_next <= CW'(AE_LEVEL));
        end
    end

    // The storage array is not reset. wr_ptr only equals rd_ptr when the FIFO
    // is empty or full, and in those states either the read or the write is
    // rejected, so a read never collides with a write to the same entry.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= din;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // The head entry is always presented on dout. Its value only has
            // meaning while !empty.
            assign dout = mem[rd_ptr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem[rd_ptr];
                end
            end

            assign dout = dout_q;
        end
    endgenerate

`ifdef UART_FIFO_ERR_FLAGS_EN
    // Sticky error flags. If clr_err and a new error occur in the same cycle,
    // the clear takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr_err) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en & full)  overflow  <= 1'b1;
            if (rd_en & empty) underflow <= 1'b1;
        end
    end
`else
    logic unused_clr_err;

    assign unused_clr_err = clr_err;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_uart_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_sync_fifo
//   Directed testbench for uart_sync_fifo.
//   u_std is the default configuration (FWFT=0).
//   u_fwft is the same FIFO with FWFT=1.
//   Expected error-flag values follow UART_FIFO_ERR_FLAGS_EN.
// -----------------------------------------------------------------------------
module tb_uart_sync_fifo;

`ifdef UART_FIFO_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, rd_en, clr_err;
    logic [7:0] din;
    logic [7:0] dout;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0] count;

    logic       wr1, rd1, clr1;
    logic [7:0] din1;
    logic [7:0] dout1;
    logic       full1, empty1, af1, ae1, ov1, un1;
    logic [4:0] count1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_sync_fifo u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .clr_err(clr_err),
        .overflow(overflow), .underflow(underflow)
    );

    uart_sync_fifo #(.FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr1), .din(din1), .rd_en(rd1),
        .dout(dout1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(count1), .clr_err(clr1),
        .overflow(ov1), .underflow(un1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b want 1", empty); end
        tests++; if (almost_empty !== 1'b1) begin fails++; $display("FAIL reset_ae: got %b want 1", almost_empty); end
        tests++; if (full !== 1'b0 || almost_full !== 1'b0) begin fails++; $display("FAIL reset_full_af: got %b%b want 00", full, almost_full); end
        tests++; if (dout !== 8'h00) begin fails++; $display("FAIL reset_dout: got %h want 00", dout); end
        tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin fails++; $display("FAIL reset_err: got %b%b want 00", overflow, underflow); end
        @(negedge clk) rst = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; din = 8'h31 + 8'(i);
            tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tests++; if (dout !== 8'h31) begin fails++; $display("FAIL first_read: got %h want 31", dout); end
        wr_en = 1'b1; din = 8'h36;
        tick();
        wr_en = 1'b0;
        tests++; if (count !== 5'd5) begin fails++; $display("FAIL pre_reset_count: got %0d want 5", count); end
        // Assert reset between clock edges; the outputs must clear immediately.
        #2 rst = 1'b1;
        #1;
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL midrst_count: got %0d want 0", count); end
        tests++; if (empty !== 1'b1 || almost_empty !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL midrst_flags: got e%b ae%b f%b want e1 ae1 f0", empty, almost_empty, full); end
        tests++; if (dout !== 8'h00) begin fails++; $display("FAIL midrst_dout: got %h want 00", dout); end
        @(negedge clk) rst = 1'b0;
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; din = 8'(i);
            tick();
            tests++; if (almost_full !== (i + 1 >= 12)) begin fails++; $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, (i + 1 >= 12)); end
        end
        tests++; if (full !== 1'b1 || count !== 5'd16) begin fails++; $display("FAIL fill_full: got full=%b count=%0d want 1/16", full, count); end
        din = 8'hAA;
        tick();
        wr_en = 1'b0;
        tests++; if (count !== 5'd16 || full !== 1'b1) begin fails++; $display("FAIL overwrite_count: got %0d want 16", count); end
        tests++; if (overflow !== ERR_EN) begin fails++; $display("FAIL overflow_set: got %b want %b", overflow, ERR_EN); end
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1;
            tick();
            tests++; if (dout !== 8'(i)) begin fails++; $display("FAIL fill_read[%0d]: got %h want %h", i, dout, 8'(i)); end
        end
        rd_en = 1'b0;
        tests++; if (empty !== 1'b1 || count !== 5'd0 || almost_empty !== 1'b1) begin fails++; $display("FAIL drained: got e%b c%0d want e1 c0", empty, count); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        for (int i = 0; i < 7; i++) begin
            wr_en = 1'b1; din = 8'h40 + 8'(i);
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; din = 8'h50 + 8'(i);
            tick();
            exp = (i < 7) ? 8'h40 + 8'(i) : 8'h50 + 8'(i - 7);
            tests++; if (count !== 5'd7) begin fails++; $display("FAIL simul_count[%0d]: got %0d want 7", i, count); end
            tests++; if (dout !== exp) begin fails++; $display("FAIL simul_data[%0d]: got %h want %h", i, dout, exp); end
        end
        wr_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            tests++; if (dout !== 8'h53 + 8'(i)) begin fails++; $display("FAIL simul_drain[%0d]: got %h want %h", i, dout, 8'h53 + 8'(i)); end
        end
        rd_en = 1'b0;
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL simul_end: got %0d want 0", count); end
    endtask

    task automatic test_boundaries();
        wr_en = 1'b1; rd_en = 1'b1; din = 8'h77;
        tick();
        tests++; if (count !== 5'd1 || empty !== 1'b0) begin fails++; $display("FAIL empty_rw_count: got %0d want 1", count); end
        tests++; if (underflow !== ERR_EN) begin fails++; $display("FAIL underflow_set: got %b want %b", underflow, ERR_EN); end
        tests++; if (dout !== 8'h59) begin fails++; $display("FAIL empty_rw_dout: got %h want 59", dout); end
        rd_en = 1'b0;
        for (int i = 0; i < 15; i++) begin
            din = 8'h80 + 8'(i);
            tick();
        end
        tests++; if (full !== 1'b1 || count !== 5'd16) begin fails++; $display("FAIL refill: got f%b c%0d want f1 c16", full, count); end
        rd_en = 1'b1; din = 8'hEE;
        tick();
        wr_en = 1'b0;
        tests++; if (count !== 5'd15 || full !== 1'b0) begin fails++; $display("FAIL full_rw_count: got %0d want 15", count); end
        tests++; if (dout !== 8'h77) begin fails++; $display("FAIL full_rw_dout: got %h want 77", dout); end
        tests++; if (overflow !== ERR_EN) begin fails++; $display("FAIL overflow_full_rw: got %b want %b", overflow, ERR_EN); end
        for (int i = 0; i < 15; i++) begin
            tick();
            tests++; if (dout !== 8'h80 + 8'(i)) begin fails++; $display("FAIL full_drain[%0d]: got %h want %h", i, dout, 8'h80 + 8'(i)); end
        end
        rd_en = 1'b0;
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL full_drain_empty: got %b want 1", empty); end
    endtask

    task automatic test_errors();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin fails++; $display("FAIL clr_err: got %b%b want 00", overflow, underflow); end
        rd_en = 1'b1;
        tick();
        tests++; if (underflow !== ERR_EN) begin fails++; $display("FAIL underflow_again: got %b want %b", underflow, ERR_EN); end
        clr_err = 1'b1;
        tick();
        rd_en = 1'b0; clr_err = 1'b0;
        tests++; if (underflow !== 1'b0) begin fails++; $display("FAIL clr_priority: got %b want 0", underflow); end
        tests++; if (count !== 5'd0 || dout !== 8'h8E) begin fails++; $display("FAIL reject_state: got c%0d d%h want c0 d8e", count, dout); end
    endtask

    task automatic test_fwft();
        tests++; if (empty1 !== 1'b1) begin fails++; $display("FAIL fwft_init_empty: got %b want 1", empty1); end
        wr1 = 1'b1; din1 = 8'h5A;
        tick();
        wr1 = 1'b0;
        tests++; if (empty1 !== 1'b0 || dout1 !== 8'h5A) begin fails++; $display("FAIL fwft_fall: got e%b d%h want e0 d5a", empty1, dout1); end
        tick();
        tests++; if (dout1 !== 8'h5A || count1 !== 5'd1) begin fails++; $display("FAIL fwft_hold: got d%h c%0d want d5a c1", dout1, count1); end
        wr1 = 1'b1; din1 = 8'h6B;
        tick();
        wr1 = 1'b0;
        tests++; if (dout1 !== 8'h5A || count1 !== 5'd2) begin fails++; $display("FAIL fwft_head: got d%h c%0d want d5a c2", dout1, count1); end
        rd1 = 1'b1;
        tick();
        tests++; if (dout1 !== 8'h6B || count1 !== 5'd1) begin fails++; $display("FAIL fwft_pop1: got d%h c%0d want d6b c1", dout1, count1); end
        tick();
        rd1 = 1'b0;
        tests++; if (empty1 !== 1'b1 || count1 !== 5'd0) begin fails++; $display("FAIL fwft_pop2: got e%b c%0d want e1 c0", empty1, count1); end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
        wr1 = 1'b0; rd1 = 1'b0; clr1 = 1'b0; din1 = '0;
        test_reset();
        test_fill();
        test_back_to_back();
        test_boundaries();
        test_errors();
        test_fwft();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
